// File: rtl/card_dealer.sv
// Deals pseudo-random, never-repeated cards from a 52-card deck.
// A Galois LFSR picks a start slot; PROBE walks forward to the next free slot.
module card_dealer #(
  parameter logic [15:0] SEED      = 16'h0033,
  parameter int          DECK_SIZE = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle,
  input  logic       deal_req,
  output logic [5:0] card_out,
  output logic       card_valid,
  output logic       deal_err,
  output logic       busy,
  output logic       deck_empty,
  output logic [5:0] cards_left
);

  localparam logic [15:0] SEED_L = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [5:0]  NCARDS = 6'(DECK_SIZE);
  localparam logic [5:0]  LAST   = 6'(DECK_SIZE - 1);

  typedef enum logic {IDLE, PROBE} state_t;

  state_t                 state, state_nxt;
  logic [DECK_SIZE-1:0]   used;
  logic [15:0]            lfsr, lfsr_nxt;
  logic [5:0]             idx, start, r;
  logic                   take, grant, empty_req;

  always_comb begin
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    r         = lfsr[5:0];
    start     = (r >= NCARDS) ? r - NCARDS : r;
    state_nxt = state;
    take      = 1'b0;
    grant     = 1'b0;
    empty_req = 1'b0;
    case (state)
      IDLE: begin
        if (deal_req) begin
          if (cards_left != 6'd0) begin
            take      = 1'b1;
            state_nxt = PROBE;
          end else begin
            empty_req = 1'b1;
          end
        end
      end
      PROBE: begin
        if (!used[idx]) begin
          grant     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // shuffle aborts anything in flight and drops a same-cycle request
    if (shuffle) begin
      state_nxt = IDLE;
      take      = 1'b0;
      grant     = 1'b0;
      empty_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used       <= '0;
      cards_left <= NCARDS;
      lfsr       <= SEED_L;
      idx        <= 6'd0;
      card_out   <= 6'd0;
      card_valid <= 1'b0;
      deal_err   <= 1'b0;
    end else begin
      lfsr       <= lfsr_nxt;
      card_valid <= grant;
      deal_err   <= empty_req;
      if (shuffle) begin
        used       <= '0;
        cards_left <= NCARDS;
      end else begin
        if (take)
          idx <= start;
        else if (state == PROBE && used[idx])
          idx <= (idx == LAST) ? 6'd0 : idx + 6'd1;
        if (grant) begin
          used[idx]  <= 1'b1;
          card_out   <= idx;
          cards_left <= cards_left - 6'd1;
        end
      end
    end
  end

  assign busy       = (state == PROBE);
  assign deck_empty = (cards_left == 6'd0);

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Upstream dealing stage for the card display path. It holds a 52-card deck as a "dealt" bitmap.
- On each request it draws a pseudo-random card that has not yet been dealt. The card is a number 0–51, encoded as suit*13 + rank: suit 0 D, 1 H, 2 C, 3 S; rank 0 = Ace … 12 = King.
- The card is presented with a one-cycle valid pulse, ready for the card-to-digit converter.
- A shuffle input returns every card to the deck.

Parameters:
- SEED, 16'h0033: LFSR reset value. 0 is illegal; if SEED is 0, reset loads 16'h0001.
- DECK_SIZE, 52: number of cards. Fixed at 52; card_out is 6 bits wide.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- shuffle  input  1  level-sampled. When high in a cycle, returns all cards to the deck.
- deal_req  input  1  sampled only in IDLE. Requests one card.
- card_out  output  6  last dealt card, 0–51. Holds its value until the next deal.
- card_valid  output  1  one-cycle pulse; card_out is new in this cycle.
- deal_err  output  1  one-cycle pulse; a request arrived while the deck was empty.
- busy  output  1  high while in PROBE state.
- deck_empty  output  1  high when cards_left == 0.
- cards_left  output  6  cards remaining, 52 down to 0.

Behaviour:
- Reset (rst=1 at an edge):
  - used[51:0] = 0, cards_left = 52, lfsr = SEED, state = IDLE.
  - card_out = 0, card_valid = 0, deal_err = 0, busy = 0, deck_empty = 0.
- LFSR:
  - 16-bit Galois right-shift, advancing every cycle when not in reset.
  - Next value = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000).
  - Never reaches zero.
- Start index: computed from the lfsr value present in the cycle deal_req is sampled.
  - r = lfsr[5:0]; start = (r >= 52) ? r - 52 : r, giving a value in 0–51.
- States IDLE, PROBE:
  - IDLE, deal_req=1, cards_left>0: idx <= start; go to PROBE; busy=1 from the next cycle.
  - IDLE, deal_req=1, cards_left==0: deal_err pulses in the next cycle; stay in IDLE.
  - PROBE, used[idx]==0, all in the same edge:
    - used[idx] <= 1, card_out <= idx, card_valid <= 1, cards_left <= cards_left - 1;
    - state returns to IDLE.
  - PROBE, used[idx]==1: idx <= (idx==51) ? 0 : idx+1; stay in PROBE.
- Latency and rate:
  - deal_req sampled at edge N leads to the first probe at edge N+1.
  - card_valid is high in the cycle after edge N+1+k, where k is the number of occupied slots skipped. Bounds: 2 ≤ latency ≤ 53 cycles.
  - No more than one card per request. The earliest next request is accepted in the cycle card_valid is high, because state is already IDLE.
- deal_req handling:
  - Ignored while busy; not queued.
  - A level held high in IDLE starts a new deal each time IDLE is reached.
- shuffle (priority over everything except rst):
  - used <= 0, cards_left <= 52, state <= IDLE.
  - Any probe in flight is aborted; no card_valid or deal_err for it.
  - card_out is unchanged. The LFSR is not reseeded.
  - shuffle and deal_req in the same cycle: shuffle wins and the request is dropped.
- Derived outputs:
  - deck_empty = (cards_left == 0), combinational from the register.
  - busy = (state == PROBE).
- Reset mid-probe: abort immediately; all reset values apply at that edge.
- Invariant: cards_left always equals 52 minus the popcount of used. No card is dealt twice between shuffles.

Test Plan:
1. SEED=16'h0033: release reset, assert deal_req in the first cycle after reset → card_valid 2 cycles later with card_out=51, cards_left=51, busy high for exactly 1 cycle.
2. Hold deal_req high for 52 deals → 52 card_valid pulses, all card_out values distinct and covering 0–51, final cards_left=0, deck_empty=1.
3. Empty deck, pulse deal_req → deal_err high for 1 cycle, no card_valid, cards_left stays 0.
4. Deal 51 cards, then request the last one → that card is the single missing value. Measured latency is between 2 and 53 cycles, and card_valid is 1 cycle wide.
5. Assert shuffle during PROBE with deal_req also high → no card_valid or deal_err, cards_left=52, deck_empty=0, busy=0 next cycle, card_out unchanged.
6. Assert rst mid-probe after 10 deals → all outputs at reset values next cycle. A repeat of scenario 1 then gives card_out=51 again.
